// File: rtl/vend_credit_fsm_if.sv
// rtl/vend_credit_fsm_if.sv - coin/cancel pulses in, dispense/change strobes and credit out
interface vend_credit_fsm_if #(
  parameter int CW = 7
);
  logic          nickel;
  logic          dime;
  logic          cancel;
  logic          dispense;
  logic          change_nickel;
  logic          busy;
  logic [CW-1:0] credit;

  modport master (
    output nickel, dime, cancel,
    input  dispense, change_nickel, busy, credit
  );

  modport slave (
    input  nickel, dime, cancel,
    output dispense, change_nickel, busy, credit
  );
endinterface

// File: rtl/vend_credit_fsm.sv
// rtl/vend_credit_fsm.sv - credit-accumulating vending controller
// Accumulates coin credit, strobes dispense at PRICE and pays back the excess in nickels.
module vend_credit_fsm #(
  parameter int PRICE = 15,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  vend_credit_fsm_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    REFUND = 2'd3
  } state_t;

  localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
  localparam logic [CW-1:0] NICKEL_C = CW'(5);
  localparam logic [CW-1:0] DIME_C   = CW'(10);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          dispense_q, dispense_d;
  logic          change_q, change_d;
  logic [CW-1:0] sum;

  always_comb begin
    sum = credit_q + (bus.nickel ? NICKEL_C : '0) + (bus.dime ? DIME_C : '0);
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = 1'b0;
    change_d   = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        // Cancel takes priority over reaching the price: everything goes back.
        if (bus.cancel) begin
          if (sum != '0) begin
            credit_d = sum;
            state_d  = REFUND;
          end
        end else if (sum >= PRICE_C) begin
          credit_d = sum;
          state_d  = VEND;
        end else if (sum != '0) begin
          credit_d = sum;
          state_d  = ACCUM;
        end
      end
      VEND: begin
        dispense_d = 1'b1;
        credit_d   = credit_q - PRICE_C;
        state_d    = (credit_q == PRICE_C) ? IDLE : REFUND;
      end
      REFUND: begin
        change_d = 1'b1;
        credit_d = credit_q - NICKEL_C;
        if (credit_q == NICKEL_C) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      dispense_q <= 1'b0;
      change_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      change_q   <= change_d;
    end
  end

  assign bus.dispense      = dispense_q;
  assign bus.change_nickel = change_q;
  assign bus.credit        = credit_q;
  assign bus.busy          = (state_q == VEND) || (state_q == REFUND);
endmodule

// File: tb/tb_vend_credit_fsm.sv
// tb/tb_vend_credit_fsm.sv - randomized and directed bench for vend_credit_fsm
// Reference model: a transaction queue of future output cycles scheduled when a sale or cancel happens.
module tb_vend_credit_fsm;
  localparam int PRICE = 15;
  localparam int CW    = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vend_credit_fsm_if #(.CW(CW)) bus ();
  vend_credit_fsm #(.PRICE(PRICE), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit disp;
    bit chg;
    int credit;
    bit busy;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t e;
  int   m_credit = 0;

  function automatic exp_t mk(bit disp, bit chg, int credit, bit busy);
    exp_t r;
    r.disp = disp; r.chg = chg; r.credit = credit; r.busy = busy;
    return r;
  endfunction

  // Once a sale or refund starts, its whole output sequence is known up front.
  function void model_step(bit n, bit d, bit c);
    int sum, rem;
    if (q.size() > 0) begin
      e = q.pop_front();
    end else begin
      sum = m_credit + 5 * int'(n) + 10 * int'(d);
      e = mk(1'b0, 1'b0, m_credit, 1'b0);
      if (c) begin
        if (sum > 0) begin
          e = mk(1'b0, 1'b0, sum, 1'b1);
          for (int k = 1; k <= sum / 5; k++) q.push_back(mk(1'b0, 1'b1, sum - 5 * k, (sum - 5 * k) > 0));
        end
      end else if (sum >= PRICE) begin
        e = mk(1'b0, 1'b0, sum, 1'b1);
        rem = sum - PRICE;
        q.push_back(mk(1'b1, 1'b0, rem, rem > 0));
        for (int k = 1; k <= rem / 5; k++) q.push_back(mk(1'b0, 1'b1, rem - 5 * k, (rem - 5 * k) > 0));
      end else begin
        e = mk(1'b0, 1'b0, sum, 1'b0);
      end
    end
    m_credit = e.credit;
  endfunction

  task automatic cycle(input bit n, input bit d, input bit c);
    @(negedge clk);
    bus.nickel = n; bus.dime = d; bus.cancel = c;
    @(posedge clk);
    #1;
    model_step(n, d, c);
    bus.nickel = 1'b0; bus.dime = 1'b0; bus.cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.nickel = 1'b0; bus.dime = 1'b0; bus.cancel = 1'b0;
    #3;
    checks++;
    if (bus.credit !== '0 || bus.dispense !== 1'b0 || bus.change_nickel !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got credit=%0d disp=%b chg=%b busy=%b, want 0 0 0 0",
               bus.credit, bus.dispense, bus.change_nickel, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_credit = 0;
  endtask

  // Each entry is {nickel, dime, cancel}; want_d/want_c are the expected pulse totals.
  task automatic run_seq(input string name, input logic [2:0] s[], input int want_d, input int want_c);
    int nd = 0, nc = 0;
    foreach (s[i]) begin
      cycle(s[i][2], s[i][1], s[i][0]);
      nd += int'(bus.dispense);
      nc += int'(bus.change_nickel);
      checks++;
      if (bus.dispense !== e.disp || bus.change_nickel !== e.chg || bus.busy !== e.busy ||
          bus.credit !== CW'(e.credit)) begin
        errors++;
        $display("FAIL %s cyc%0d: got disp=%b chg=%b busy=%b credit=%0d, want %b %b %b %0d",
                 name, i, bus.dispense, bus.change_nickel, bus.busy, bus.credit,
                 e.disp, e.chg, e.busy, e.credit);
      end
    end
    checks++;
    if (nd !== want_d || nc !== want_c) begin
      errors++;
      $display("FAIL %s_counts: got dispense=%0d change=%0d, want %0d %0d", name, nd, nc, want_d, want_c);
    end
    checks++;
    if (bus.credit !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: got credit=%0d busy=%b, want 0 0", name, bus.credit, bus.busy);
    end
  endtask

  task automatic test_three_nickels();
    logic [2:0] s[] = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
    run_seq("three_nickels", s, 1, 0);
  endtask

  task automatic test_two_dimes_change();
    logic [2:0] s[] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    run_seq("two_dimes", s, 1, 1);
  endtask

  task automatic test_nickel_dime_same_cycle();
    logic [2:0] s[] = '{3'b110, 3'b000, 3'b000, 3'b000};
    run_seq("nickel_dime", s, 1, 0);
  endtask

  task automatic test_cancel();
    logic [2:0] s1[] = '{3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
    logic [2:0] s2[] = '{3'b010, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] s3[] = '{3'b001, 3'b000};
    run_seq("dime_cancel", s1, 0, 2);
    run_seq("cancel_with_nickel", s2, 0, 3);
    run_seq("cancel_empty", s3, 0, 0);
  endtask

  task automatic test_ignore_when_busy();
    logic [2:0] s[] = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b000, 3'b000};
    run_seq("ignore_busy", s, 1, 1);
  endtask

  task automatic test_async_reset_mid_refund();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.change_nickel !== 1'b1 || bus.credit !== CW'(10) || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_refund: got chg=%b credit=%0d busy=%b, want 1 10 1",
               bus.change_nickel, bus.credit, bus.busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.credit !== '0 || bus.dispense !== 1'b0 || bus.change_nickel !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got credit=%0d disp=%b chg=%b busy=%b, want 0 0 0 0",
               bus.credit, bus.dispense, bus.change_nickel, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_credit = 0;
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.credit !== '0 || bus.change_nickel !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got credit=%0d chg=%b busy=%b, want 0 0 0",
               bus.credit, bus.change_nickel, bus.busy);
    end
  endtask

  task automatic test_random();
    bit n, d, c;
    for (int i = 0; i < 400; i++) begin
      n = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 9) == 0);
      cycle(n, d, c);
      checks++;
      if (bus.dispense !== e.disp || bus.change_nickel !== e.chg || bus.busy !== e.busy ||
          bus.credit !== CW'(e.credit)) begin
        errors++;
        $display("FAIL random cyc%0d (n=%b d=%b c=%b): got disp=%b chg=%b busy=%b credit=%0d, want %b %b %b %0d",
                 i, n, d, c, bus.dispense, bus.change_nickel, bus.busy, bus.credit,
                 e.disp, e.chg, e.busy, e.credit);
      end
      checks++;
      if (bus.dispense === 1'b1 && bus.change_nickel === 1'b1) begin
        errors++;
        $display("FAIL random_exclusive cyc%0d: got dispense=1 change=1, want not both", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_nickels();
    test_two_dimes_change();
    test_nickel_dime_same_cycle();
    test_cancel();
    test_ignore_when_busy();
    test_async_reset_mid_refund();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
